// File: rtl/soc_event_arbiter.sv
// Collects single-cycle peripheral event pulses into saturating per-source counters and
// serialises them round-robin into a registered valid/fulln/data event-ID stream.
module soc_event_arbiter #(
  parameter int unsigned NB_EVENTS      = 16,
  parameter int unsigned EVENT_ID_WIDTH = 8,
  parameter int unsigned CNT_WIDTH      = 2,
  parameter int unsigned ID_OFFSET      = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NB_EVENTS-1:0]      events_i,
  input  logic [NB_EVENTS-1:0]      err_clr_i,
  output logic                      event_fifo_valid_o,
  input  logic                      event_fifo_fulln_i,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  output logic [NB_EVENTS-1:0]      err_o,
  output logic                      busy_o
);

  localparam int unsigned PtrW = $clog2(NB_EVENTS);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  cnt_t                      cnt_q [NB_EVENTS];
  cnt_t                      cnt_d [NB_EVENTS];
  logic [NB_EVENTS-1:0]      err_q, err_d;
  logic [NB_EVENTS-1:0]      pending;
  logic [NB_EVENTS-1:0]      dec_vec;
  logic                      valid_q, valid_d;
  logic [EVENT_ID_WIDTH-1:0] data_q, data_d;
  logic [PtrW-1:0]           ptr_q, ptr_d;

  logic                      load_en;
  logic                      gnt_found;
  logic [PtrW-1:0]           gnt_idx;
  logic [PtrW:0]             scan_idx;

  always_comb begin
    for (int unsigned i = 0; i < NB_EVENTS; i++) begin
      pending[i] = (cnt_q[i] != '0);
    end
  end

  // The output register can take a new ID when empty or when its content leaves this cycle.
  assign load_en = !valid_q || event_fifo_fulln_i;

  // Round-robin scan from ptr_q, wrapping modulo NB_EVENTS; first pending source wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NB_EVENTS; k++) begin
      scan_idx = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (scan_idx >= (PtrW+1)'(NB_EVENTS)) begin
        scan_idx = scan_idx - (PtrW+1)'(NB_EVENTS);
      end
      if (!gnt_found && pending[scan_idx[PtrW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    dec_vec = '0;
    if (load_en) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        dec_vec[gnt_idx] = 1'b1;
        data_d = EVENT_ID_WIDTH'(ID_OFFSET) + EVENT_ID_WIDTH'(gnt_idx);
        ptr_d  = (gnt_idx == PtrW'(NB_EVENTS - 1)) ? '0 : gnt_idx + PtrW'(1);
      end
    end
  end

  // A simultaneous increment and grant cancels out and never counts as an overflow.
  always_comb begin
    err_d = err_q & ~err_clr_i;
    for (int unsigned i = 0; i < NB_EVENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (events_i[i] && !dec_vec[i]) begin
        if (cnt_q[i] == CntMax) begin
          err_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end
      end else if (!events_i[i] && dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NB_EVENTS; i++) begin
        cnt_q[i] <= '0;
      end
      err_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NB_EVENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      err_q   <= err_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign event_fifo_valid_o = valid_q;
  assign event_fifo_data_o  = data_q;
  assign err_o              = err_q;
  assign busy_o             = (|pending) || valid_q;

endmodule

// File: tb/tb_soc_event_arbiter.sv
// Randomised and directed bench for soc_event_arbiter, checked every cycle against a
// queue-free integer model of pending counts, round-robin grant and sticky overflow flags.
module tb_soc_event_arbiter;

  localparam int N   = 16;
  localparam int W   = 8;
  localparam int CW  = 2;
  localparam int OFF = 0;
  localparam int MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           fulln;
  logic [N-1:0]   ev;
  logic [N-1:0]   clr;
  logic           valid;
  logic [W-1:0]   data;
  logic [N-1:0]   err;
  logic           busy;

  always #5 clk = ~clk;

  soc_event_arbiter #(
    .NB_EVENTS      (N),
    .EVENT_ID_WIDTH (W),
    .CNT_WIDTH      (CW),
    .ID_OFFSET      (OFF)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .events_i           (ev),
    .err_clr_i          (clr),
    .event_fifo_valid_o (valid),
    .event_fifo_fulln_i (fulln),
    .event_fifo_data_o  (data),
    .err_o              (err),
    .busy_o             (busy)
  );

  // Reference state
  int           m_cnt [N];
  logic [N-1:0] m_err;
  bit           m_valid;
  int           m_data;
  int           m_ptr;
  bit           started = 0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    int  grant;
    bit  load;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_err   = '0;
      m_valid = 0;
      m_data  = 0;
      m_ptr   = 0;
      started = 1;
      return;
    end
    load  = !m_valid || fulln;
    grant = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        if (grant < 0 && m_cnt[(m_ptr + k) % N] > 0) grant = (m_ptr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      bit inc, dec;
      inc = ev[i];
      dec = (grant == i);
      if (clr[i]) m_err[i] = 1'b0;
      if (inc && !dec) begin
        if (m_cnt[i] == MAX) m_err[i] = 1'b1;
        else m_cnt[i]++;
      end else if (dec && !inc) begin
        m_cnt[i]--;
      end
    end
    if (load) begin
      if (grant >= 0) begin
        m_valid = 1;
        m_data  = OFF + grant;
        m_ptr   = (grant + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  function automatic bit model_busy();
    bit b;
    b = m_valid;
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) b = 1;
    return b;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 64'(valid), 64'(m_valid));
      chk("data", 64'(data), 64'(m_data));
      chk("err", 64'(err), 64'(m_err));
      chk("busy", 64'(busy), 64'(model_busy()));
    end
  end

  task automatic step(input logic [N-1:0] e, input logic f, input logic [N-1:0] c,
                      input logic r);
    ev    = e;
    fulln = f;
    clr   = c;
    rst_n = r;
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [N-1:0] e, input logic f);
    step(e, f, '0, 1'b1);
  endtask

  logic [N-1:0] rnd_ev, rnd_clr;
  int           stall;

  initial begin
    rst_n = 1'b0;
    ev    = '1;
    fulln = 1'b1;
    clr   = '0;

    // Reset with all sources pulsing: nothing may be registered.
    step('1, 1'b1, '0, 1'b0);
    step('1, 1'b1, '0, 1'b0);
    run('0, 1'b1);
    chk("lit_reset_valid", 64'(valid), 64'd0);
    chk("lit_reset_err", 64'(err), 64'd0);
    chk("lit_reset_busy", 64'(busy), 64'd0);

    // Single event: counter after edge k, output after edge k+1.
    run(N'(1) << 5, 1'b1);
    chk("lit_single_lat_valid", 64'(valid), 64'd0);
    chk("lit_single_lat_busy", 64'(busy), 64'd1);
    run('0, 1'b1);
    chk("lit_single_valid", 64'(valid), 64'd1);
    chk("lit_single_data", 64'(data), 64'd5);
    run('0, 1'b1);
    chk("lit_single_drain", 64'(valid), 64'd0);
    chk("lit_single_idle", 64'(busy), 64'd0);

    // Round-robin from pointer 0.
    step('0, 1'b1, '0, 1'b0);
    run('0, 1'b1);
    run((N'(1) << 3) | (N'(1) << 7) | (N'(1) << 12), 1'b1);
    run('0, 1'b1);
    chk("lit_rr_0", 64'(data), 64'd3);
    run('0, 1'b1);
    chk("lit_rr_1", 64'(data), 64'd7);
    run('0, 1'b1);
    chk("lit_rr_2", 64'(data), 64'd12);
    chk("lit_rr_2v", 64'(valid), 64'd1);
    run('0, 1'b1);
    chk("lit_rr_end", 64'(valid), 64'd0);
    // Pointer now 13: source 3 precedes 12 after wrap.
    run((N'(1) << 3) | (N'(1) << 12), 1'b1);
    run('0, 1'b1);
    chk("lit_wrap_0", 64'(data), 64'd3);
    run('0, 1'b1);
    chk("lit_wrap_1", 64'(data), 64'd12);
    run('0, 1'b1);
    chk("lit_wrap_end", 64'(valid), 64'd0);

    // Backpressure holds ID 7 while source 2 queues behind it.
    run(N'(1) << 7, 1'b1);
    run('0, 1'b0);
    run(N'(1) << 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run('0, 1'b0);
      chk("lit_bp_hold_valid", 64'(valid), 64'd1);
      chk("lit_bp_hold_data", 64'(data), 64'd7);
    end
    run('0, 1'b1);
    chk("lit_bp_next", 64'(data), 64'd2);
    run('0, 1'b1);
    chk("lit_bp_end", 64'(valid), 64'd0);

    // Saturation: five pulses on source 9 with output stalled on ID 1.
    run(N'(1) << 1, 1'b0);
    run(N'(1) << 9, 1'b0);
    for (int i = 0; i < 4; i++) run(N'(1) << 9, 1'b0);
    chk("lit_sat_err", 64'(err[9]), 64'd1);
    chk("lit_sat_data", 64'(data), 64'd1);
    step(N'(1) << 9, 1'b0, N'(1) << 9, 1'b1);
    chk("lit_sat_setwins", 64'(err[9]), 64'd1);
    step('0, 1'b0, N'(1) << 9, 1'b1);
    chk("lit_sat_clr", 64'(err[9]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      run('0, 1'b1);
      chk("lit_sat_emit", 64'(data), 64'd9);
    end
    run('0, 1'b1);
    chk("lit_sat_exact3", 64'(valid), 64'd0);

    // Simultaneous inc/dec at max: count stays 3, no overflow.
    run(N'(1) << 0, 1'b0);
    run(N'(1) << 4, 1'b0);
    chk("lit_sim_hold", 64'(data), 64'd0);
    run(N'(1) << 4, 1'b0);
    run(N'(1) << 4, 1'b0);
    run(N'(1) << 4, 1'b1);
    chk("lit_sim_data", 64'(data), 64'd4);
    chk("lit_sim_err", 64'(err[4]), 64'd0);
    for (int i = 0; i < 3; i++) begin
      run('0, 1'b1);
      chk("lit_sim_emit", 64'(data), 64'd4);
    end
    run('0, 1'b1);
    chk("lit_sim_end", 64'(valid), 64'd0);

    // Random traffic with stall bursts, sparse clears and rare resets.
    stall = 0;
    for (int c = 0; c < 4000; c++) begin
      rnd_ev  = N'($urandom & $urandom & $urandom);
      rnd_clr = N'($urandom & $urandom & $urandom & $urandom);
      if (stall == 0 && $urandom_range(0, 63) == 0) stall = $urandom_range(4, 20);
      if (stall > 0) stall--;
      step(rnd_ev, (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0), rnd_clr,
           ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
    end
    run('0, 1'b1);
    for (int c = 0; c < 4 * N; c++) run('0, 1'b1);
    chk("lit_final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
